// File: rtl/conv_encoder_soft.sv
// Rate-1/2 convolutional encoder with a soft-symbol mapper (I = G1 parity, Q = G2 parity) and zero-tail flush.
// Optional build macro CONV_ENC_NOISE_EN adds Galois-LFSR noise to every emitted symbol.

module conv_encoder_soft #(
    parameter int unsigned  K       = 7,
    parameter logic [K-1:0] G1      = 7'h79,
    parameter logic [K-1:0] G2      = 7'h5B,
    parameter int unsigned  SOFT_W  = 8,
    parameter int unsigned  NOISE_W = 3
) (
    input  logic                     clk,
    input  logic                     sys_rst,
    input  logic                     clr,
    input  logic                     in_bit,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic signed [SOFT_W-1:0] out_sym,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_phase,
    output logic                     out_last,
    output logic                     flush_done
);

    localparam int unsigned S_W   = K - 1;
    localparam int unsigned CNT_W = $clog2(K);
    localparam int unsigned SUM_W = SOFT_W + 1;

    localparam logic [SOFT_W-1:0] SYM_POS  = {1'b0, {(SOFT_W-1){1'b1}}};
    localparam logic [SOFT_W-1:0] SYM_NEG  = {1'b1, {(SOFT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  TAIL_LEN = CNT_W'(K - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYM_I  = 3'd1,
        SYM_Q  = 3'd2,
        TAIL_I = 3'd3,
        TAIL_Q = 3'd4
    } fsm_t;

    fsm_t             fsm;
    logic [S_W-1:0]   sr;
    logic             q_par;
    logic             tail_pend;
    logic [CNT_W-1:0] tail_cnt;
    logic [NOISE_W:0] noise;

    function automatic logic parity(input logic [K-1:0] v, input logic [K-1:0] g);
        return ^(v & g);
    endfunction

    // Extreme code plus signed noise, clamped back into the SOFT_W range.
    function automatic logic [SOFT_W-1:0] soft_map(input logic par, input logic [NOISE_W:0] n);
        logic [SOFT_W-1:0] ideal;
        logic [SUM_W-1:0]  sum;
        logic [SOFT_W-1:0] res;
        ideal = par ? SYM_POS : SYM_NEG;
        sum   = {ideal[SOFT_W-1], ideal} + {{(SUM_W-NOISE_W-1){n[NOISE_W]}}, n};
        if (sum[SUM_W-1] != sum[SUM_W-2]) begin
            res = sum[SUM_W-1] ? SYM_NEG : SYM_POS;
        end else begin
            res = sum[SOFT_W-1:0];
        end
        return res;
    endfunction

`ifdef CONV_ENC_NOISE_EN
    logic        sym_acc;
    logic [15:0] lfsr;
    logic [15:0] lfsr_d;

    assign sym_acc = out_valid && out_ready;

    // Noise for a freshly loaded symbol uses the post-advance LFSR value.
    always_comb begin
        lfsr_d = lfsr;
        if (sym_acc) begin
            lfsr_d = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            lfsr <= 16'hACE1;
        end else if (clr) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= lfsr_d;
        end
    end

    assign noise = lfsr_d[NOISE_W:0];
`else
    assign noise = '0;
`endif

    logic [K-1:0]      data_vec;
    logic [K-1:0]      tail_vec;
    logic [SOFT_W-1:0] data_sym;
    logic [SOFT_W-1:0] tail_sym;
    logic [SOFT_W-1:0] q_sym;

    assign data_vec = {in_bit, sr};
    assign tail_vec = {1'b0, sr};
    assign data_sym = soft_map(parity(data_vec, G1), noise);
    assign tail_sym = soft_map(parity(tail_vec, G1), noise);
    assign q_sym    = soft_map(q_par, noise);

    // Combinational so a new bit can be taken in the cycle the Q symbol leaves.
    assign in_ready = !sys_rst && !clr &&
                      ((fsm == IDLE) || ((fsm == SYM_Q) && out_ready && !tail_pend));

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            fsm        <= IDLE;
            sr         <= '0;
            q_par      <= 1'b0;
            tail_pend  <= 1'b0;
            tail_cnt   <= '0;
            out_sym    <= '0;
            out_valid  <= 1'b0;
            out_phase  <= 1'b0;
            out_last   <= 1'b0;
            flush_done <= 1'b0;
        end else if (clr) begin
            fsm        <= IDLE;
            sr         <= '0;
            q_par      <= 1'b0;
            tail_pend  <= 1'b0;
            tail_cnt   <= '0;
            out_sym    <= '0;
            out_valid  <= 1'b0;
            out_phase  <= 1'b0;
            out_last   <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        out_sym   <= data_sym;
                        out_valid <= 1'b1;
                        out_phase <= 1'b0;
                        q_par     <= parity(data_vec, G2);
                        sr        <= {in_bit, sr[S_W-1:1]};
                        fsm       <= SYM_I;
                    end else if (flush) begin
                        out_sym   <= tail_sym;
                        out_valid <= 1'b1;
                        out_phase <= 1'b0;
                        q_par     <= parity(tail_vec, G2);
                        sr        <= {1'b0, sr[S_W-1:1]};
                        tail_cnt  <= TAIL_LEN;
                        fsm       <= TAIL_I;
                    end
                end
                SYM_I: begin
                    if (out_ready) begin
                        out_sym   <= q_sym;
                        out_phase <= 1'b1;
                        fsm       <= SYM_Q;
                    end
                end
                SYM_Q: begin
                    if (out_ready) begin
                        if (in_valid && !tail_pend) begin
                            out_sym   <= data_sym;
                            out_phase <= 1'b0;
                            q_par     <= parity(data_vec, G2);
                            sr        <= {in_bit, sr[S_W-1:1]};
                            fsm       <= SYM_I;
                        end else if (tail_pend || flush) begin
                            out_sym   <= tail_sym;
                            out_phase <= 1'b0;
                            q_par     <= parity(tail_vec, G2);
                            sr        <= {1'b0, sr[S_W-1:1]};
                            tail_cnt  <= TAIL_LEN;
                            tail_pend <= 1'b0;
                            fsm       <= TAIL_I;
                        end else begin
                            out_sym   <= '0;
                            out_valid <= 1'b0;
                            out_phase <= 1'b0;
                            fsm       <= IDLE;
                        end
                    end else if (flush && !in_valid) begin
                        tail_pend <= 1'b1;
                    end
                end
                TAIL_I: begin
                    if (out_ready) begin
                        out_sym   <= q_sym;
                        out_phase <= 1'b1;
                        out_last  <= (tail_cnt == CNT_W'(1));
                        fsm       <= TAIL_Q;
                    end
                end
                TAIL_Q: begin
                    if (out_ready) begin
                        out_last <= 1'b0;
                        if (tail_cnt == CNT_W'(1)) begin
                            tail_cnt   <= '0;
                            out_sym    <= '0;
                            out_valid  <= 1'b0;
                            out_phase  <= 1'b0;
                            flush_done <= 1'b1;
                            fsm        <= IDLE;
                        end else begin
                            tail_cnt  <= tail_cnt - CNT_W'(1);
                            out_sym   <= tail_sym;
                            out_phase <= 1'b0;
                            q_par     <= parity(tail_vec, G2);
                            sr        <= {1'b0, sr[S_W-1:1]};
                            fsm       <= TAIL_I;
                        end
                    end
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_encoder_soft.sv
// Self-checking bench for conv_encoder_soft: directed vector table, stall/flush/reset/clr sequences,
// and randomized traffic checked against a shift-history reference model.

module tb_conv_encoder_soft;

    localparam int unsigned  K      = 7;
    localparam int unsigned  SOFT_W = 8;
    localparam logic [K-1:0] G1     = 7'h79;
    localparam logic [K-1:0] G2     = 7'h5B;

    logic              clk = 1'b0;
    logic              sys_rst;
    logic              clr;
    logic              in_bit;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [SOFT_W-1:0] out_sym;
    logic              out_valid;
    logic              out_ready;
    logic              out_phase;
    logic              out_last;
    logic              flush_done;

    conv_encoder_soft #(
        .K(K), .G1(G1), .G2(G2), .SOFT_W(SOFT_W), .NOISE_W(3)
    ) dut (
        .clk(clk), .sys_rst(sys_rst), .clr(clr),
        .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .out_sym(out_sym), .out_valid(out_valid), .out_ready(out_ready),
        .out_phase(out_phase), .out_last(out_last), .flush_done(flush_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic par;
        logic phase;
        logic last;
    } exp_sym_t;

    typedef struct packed {
        logic              b;
        logic [SOFT_W-1:0] sym_i;
        logic [SOFT_W-1:0] sym_q;
    } vec_t;

    int cmp_cnt = 0;
    int err_cnt = 0;

    exp_sym_t          exp_q[$];
    logic              hist[K];
    logic              in_tail = 1'b0;
    logic              exp_fd = 1'b0;
    logic              held_valid = 1'b0;
    logic [SOFT_W-1:0] held_sym = '0;
    logic              held_phase = 1'b0;
    logic              acc_flag = 1'b0;
    logic              got_acc = 1'b0;
    logic [SOFT_W-1:0] got_sym = '0;
    logic              got_phase = 1'b0;
    int                sym_count = 0;
    int                last_count = 0;
    int                fd_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        cmp_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [SOFT_W-1:0] ideal(input logic par);
        return par ? SOFT_W'((1 << (SOFT_W - 1)) - 1) : SOFT_W'(1 << (SOFT_W - 1));
    endfunction

    function automatic bit sym_match(input logic [SOFT_W-1:0] act, input logic par);
`ifdef CONV_ENC_NOISE_EN
        int d;
        d = int'($signed(act)) - int'($signed(ideal(par)));
        return (d >= -15) && (d <= 15);
`else
        return act === ideal(par);
`endif
    endfunction

    // hist[0] is the bit being encoded, hist[j] the bit j steps older; G's MSB taps hist[0].
    function automatic logic model_parity(input logic [K-1:0] g);
        logic p;
        p = 1'b0;
        for (int j = 0; j < K; j++) p = p ^ (hist[j] & g[K-1-j]);
        return p;
    endfunction

    task automatic model_push(input logic b, input logic last);
        exp_sym_t e;
        for (int j = K - 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = b;
        e = '{par: model_parity(G1), phase: 1'b0, last: 1'b0};
        exp_q.push_back(e);
        e = '{par: model_parity(G2), phase: 1'b1, last: last};
        exp_q.push_back(e);
    endtask

    task automatic model_tail();
        for (int t = 0; t < K - 1; t++) model_push(1'b0, t == K - 2);
        in_tail = 1'b1;
    endtask

    task automatic model_clear();
        exp_q.delete();
        for (int j = 0; j < K; j++) hist[j] = 1'b0;
        in_tail    = 1'b0;
        exp_fd     = 1'b0;
        held_valid = 1'b0;
    endtask

    // One clock: drive at the falling edge, check 1 time unit later, then advance the model.
    task automatic cycle(input logic iv, input logic ib, input logic ordy, input logic fl, input logic cl);
        logic     exp_rdy;
        exp_sym_t e;
        @(negedge clk);
        in_valid  = iv;
        in_bit    = ib;
        out_ready = ordy;
        flush     = fl;
        clr       = cl;
        #1;
        got_acc  = 1'b0;
        acc_flag = iv && in_ready && !cl;
        exp_rdy  = !cl && !in_tail && (exp_q.size() == 0 || (exp_q.size() == 1 && ordy));
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("flush_done", 32'(flush_done), 32'(exp_fd));
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (flush_done) fd_count++;
        if (held_valid) begin
            chk("hold_sym", 32'(out_sym), 32'(held_sym));
            chk("hold_phase", 32'(out_phase), 32'(held_phase));
        end
        exp_fd = 1'b0;
        if (cl) begin
            model_clear();
        end else begin
            if (out_valid && ordy && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                cmp_cnt++;
                if (!sym_match(out_sym, e.par)) begin
                    err_cnt++;
                    $display("FAIL sym: got %0h, required %0h (phase %0d)", out_sym, ideal(e.par), e.phase);
                end
                chk("phase", 32'(out_phase), 32'(e.phase));
                chk("last", 32'(out_last), 32'(e.last));
                got_acc   = 1'b1;
                got_sym   = out_sym;
                got_phase = out_phase;
                sym_count++;
                if (out_last) last_count++;
                if (e.last) begin
                    exp_fd  = 1'b1;
                    in_tail = 1'b0;
                end
            end
            held_valid = out_valid && !ordy;
            held_sym   = out_sym;
            held_phase = out_phase;
            if (acc_flag) model_push(ib, 1'b0);
            if (fl && !iv && exp_rdy) model_tail();
            else if (fl && !iv && !in_tail && exp_q.size() == 1 && !ordy) model_tail();
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || exp_fd) && guard < 400) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            guard++;
        end
        chk("drain_timeout", 32'(guard >= 400), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_sym"}, 32'(out_sym), 32'd0);
        chk({tag, "_out_phase"}, 32'(out_phase), 32'd0);
        chk({tag, "_out_last"}, 32'(out_last), 32'd0);
        chk({tag, "_flush_done"}, 32'(flush_done), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    vec_t tv[3];

    task automatic run_table(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, tv[i].b, 1'b1, 1'b0, 1'b0);
            chk("tbl_accept", 32'(acc_flag), 32'd1);
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("tbl_i_phase", 32'(got_phase), 32'd0);
`ifndef CONV_ENC_NOISE_EN
            chk("tbl_i_sym", 32'(got_sym), 32'(tv[i].sym_i));
`endif
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("tbl_q_phase", 32'(got_phase), 32'd1);
`ifndef CONV_ENC_NOISE_EN
            chk("tbl_q_sym", 32'(got_sym), 32'(tv[i].sym_q));
`endif
        end
    endtask

    task automatic stream_bits(input int nbits, input bit rand_bits, input bit rand_ready);
        int  idx;
        int  c;
        int  s0;
        logic b;
        idx = 0;
        c   = 0;
        s0  = sym_count;
        b   = rand_bits ? 1'($urandom_range(0, 1)) : 1'b0;
        while (idx < nbits && c < 4000) begin
            cycle(1'b1, b, rand_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 1'b0);
            if (acc_flag) begin
                idx++;
                b = rand_bits ? 1'($urandom_range(0, 1)) : 1'(idx % 2);
            end
            c++;
        end
        chk("stream_bits", 32'(idx), 32'(nbits));
        drain();
        chk("stream_syms", 32'(sym_count - s0), 32'(2 * nbits));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0;
        int l0;
        int f0;
        tv[0] = '{b: 1'b0, sym_i: 8'h80, sym_q: 8'h80};
        tv[1] = '{b: 1'b1, sym_i: 8'h7F, sym_q: 8'h7F};
        tv[2] = '{b: 1'b0, sym_i: 8'h7F, sym_q: 8'h80};

        sys_rst = 1'b1; clr = 1'b0; in_bit = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 check_zero("reset");
        sys_rst = 1'b0;

        // Known bits from the zero state
        run_table(3);
        drain();

        // Back-to-back alternating bits, then the same under random backpressure
        stream_bits(140, 1'b0, 1'b0);
        model_clear();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        stream_bits(140, 1'b0, 1'b1);

        // Random bits followed by a flush from IDLE
        stream_bits(10, 1'b1, 1'b0);
        s0 = sym_count; l0 = last_count; f0 = fd_count;
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drain();
        chk("tail_syms", 32'(sym_count - s0), 32'(2 * (K - 1)));
        chk("tail_last", 32'(last_count - l0), 32'd1);
        chk("tail_done", 32'(fd_count - f0), 32'd1);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("post_flush_i", 32'(sym_match(got_sym, 1'b1)), 32'd1);
        drain();

        // Flush while the Q symbol is stalled, with extra flushes during the tail
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        l0 = last_count; f0 = fd_count;
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("pend_no_accept", 32'(acc_flag), 32'd0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drain();
        chk("pend_last", 32'(last_count - l0), 32'd1);
        chk("pend_done", 32'(fd_count - f0), 32'd1);

        // clr in the middle of a stream
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("clr_idle", 32'(out_valid), 32'd0);
        run_table(2);
        drain();

        // Asynchronous reset while the Q symbol is stalled
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2 sys_rst = 1'b1;
        #1 check_zero("midq_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        sys_rst = 1'b0;
        model_clear();
        run_table(2);
        drain();

        // Randomized traffic with occasional flush and clr
        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 149) == 0));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
